result_drain: RTL and testbench
===============================

Name: result_drain

Overview:
- Reader for the systolic array's accumulator chain.
- On `start`, waits a programmable settle interval so the last skewed products land. Then asserts `chain_en` for N_RESULTS cycles, capturing one accumulator per cycle into a local buffer.
- Streams the buffered results to the host/output logic over a valid/ready byte interface.
- Sits between the 2x2 array's `chain_out` and the top-level output mux.

Parameters:
- DATA_W, 8, width of each accumulator and of the output stream.
- N_RESULTS, 4, number of PEs on the chain (2x2 array).
- SETTLE_CYCLES, 3, idle cycles between `start` and the first `chain_en` cycle; legal range 0..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle request to drain; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- chain_en  out  1  shift enable to the array chain.
- chain_in  in  DATA_W  array `chain_out` (tail of chain, PE[1,1] register).
- out_data  out  DATA_W  result byte.
- out_valid  out  1  `out_data` valid.
- out_ready  in  1  consumer accepts when high together with `out_valid`.
- out_last  out  1  high with the final result byte.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; buffer contents don't-care but `out_valid` is 0.
- Chain semantics:
  - `chain_in` shows C11 while `chain_en` is low.
  - Each rising edge with `chain_en` high shifts the chain one place, zero-filling the head.
  - Sample order on the tail is C11, C10, C01, C00.
  - After N_RESULTS shifts, all accumulators are zero.
- FSM:
  - IDLE: `start`=1 → SETTLE, loading the settle counter with SETTLE_CYCLES. If SETTLE_CYCLES=0, go directly to SHIFT.
  - SETTLE: counter decrements each cycle; on reaching 1 → SHIFT next cycle. `chain_en`=0.
  - SHIFT: `chain_en`=1 for exactly N_RESULTS consecutive cycles. Each cycle, `chain_in` is written to buffer[wr_idx] (same-cycle sample, registered at the edge) and wr_idx increments. After the N_RESULTS-th cycle → SEND.
  - SEND: `out_valid`=1, `out_data`=buffer[rd_idx]. On `out_valid`&&`out_ready`, rd_idx advances. `out_last`=1 when rd_idx = N_RESULTS-1. A handshake with `out_last` → IDLE, with `done`=1 for that next cycle only.
- Latency: first `out_valid` appears SETTLE_CYCLES+N_RESULTS+1 cycles after the `start` edge (default 8).
- Handshake rules:
  - `out_data` and `out_last` stay stable while `out_valid`&&!`out_ready`.
  - `out_valid` never drops without a handshake.
  - `out_ready` held low stalls indefinitely; no timeout.
- `start` while `busy`: ignored, no queueing.
- `start` in the same cycle `done` pulses: state is IDLE, so it is accepted.
- `chain_en` is never asserted outside SHIFT. Exactly N_RESULTS `chain_en` cycles per drain.
- Async reset mid-SHIFT: `chain_en` drops immediately. The array may be left partially shifted; this is acceptable, and the array is reset by the same `rst_n`.
- No arithmetic on the data; bytes pass through unmodified.
- Index widths: $clog2(N_RESULTS); no wrap beyond N_RESULTS-1.

Optional Feature:
- Macro: DRAIN_ROW_MAJOR_EN.
- Defined: SEND reads buffer in reverse capture order, so the output stream is C00, C01, C10, C11 (row-major).
- Undefined: the output stream is in capture order, C11, C10, C01, C00.
- Timing, `out_last` and `done` are identical in both builds.

Decomposition:
- Shared package `tpu_pkg`:
  - DATA_W and N_RESULTS default constants.
  - The drain state enum (IDLE, SETTLE, SHIFT, SEND).
  - The result index typedef.
- Sub-module `result_buffer`: N_RESULTS x DATA_W register file with write port (we, wr_idx, wdata) and combinational read port (rd_idx). The FSM and counters stay in `result_drain`.

Test Plan:
- Basic drain: array holds C00=0x11, C01=0x22, C10=0x33, C11=0x44; `start` pulse, `out_ready`=1.
  - `chain_en` is high on cycles 4..7 after `start`.
  - Output is 0x44, 0x33, 0x22, 0x11 (0x11, 0x22, 0x33, 0x44 with DRAIN_ROW_MAJOR_EN).
  - `out_last` is on the 4th byte; `done` pulses once; array accumulators read 0 afterwards.
- Backpressure: same data, `out_ready` toggled 0,0,1,0,1,1,0,1.
  - Exactly 4 handshakes, in order.
  - `out_data` is stable during stalls.
  - `busy` stays high until after the last handshake.
- Start while busy: a second `start` during SETTLE and during SEND.
  - Ignored; only 4 `chain_en` cycles; only one `done`.
- SETTLE_CYCLES=0: `start` → `chain_en` high on the very next cycle; first `out_valid` 5 cycles after `start`.
- Reset mid-SHIFT: `rst_n` low after the 2nd `chain_en` cycle.
  - `chain_en`, `busy`, `out_valid` and `done` go 0 asynchronously.
  - After release, a fresh `start` drains new values 0xA0..0xA3 correctly.
- Back-to-back: `start` asserted in the `done` cycle.
  - The second drain begins; the stream is exactly 8 bytes with two `out_last` and two `done` pulses.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the systolic-array result path.
package tpu_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_N_RESULTS = 4;
  localparam int unsigned DEF_IDX_W     = $clog2(DEF_N_RESULTS);

  // Drain sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SHIFT  = 2'd2,
    SEND   = 2'd3
  } drain_state_t;

  // Index into the captured result set
  typedef logic [DEF_IDX_W-1:0] result_idx_t;

endpackage

// File: rtl/result_buffer.sv
// Small register file holding one captured accumulator per chain position.
// Synchronous write port, combinational read port; contents need no reset.
module result_buffer
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned N_RESULTS = DEF_N_RESULTS,
  parameter int unsigned IDX_W     = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [N_RESULTS];

  // Capture one word per write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wdata;
    end
  end

  assign rdata_c = mem[rd_idx];

endmodule

// File: rtl/result_drain.sv
// Accumulator-chain reader: waits for the array to settle, shifts the chain
// out into a local buffer, then streams the bytes over valid/ready.
// Build option: DRAIN_ROW_MAJOR_EN reverses the streamed order so bytes leave
// as C00, C01, C10, C11 instead of capture order C11, C10, C01, C00.
module result_drain
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned N_RESULTS     = DEF_N_RESULTS,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              chain_en,
  input  logic [DATA_W-1:0] chain_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  localparam int unsigned IDX_W = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_RESULTS - 1);
  // Settle interval is limited to 0..15 and held in a 4-bit counter
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  drain_state_t      state, state_d;
  logic [CNT_W-1:0]  settle_cnt, settle_cnt_d;
  logic [IDX_W-1:0]  wr_idx, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx, rd_idx_d;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_data_d;
  logic              done_d;
  logic              we;
  logic              handshake;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, counters and capture strobe
  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    wr_idx_d     = wr_idx;
    rd_idx_d     = rd_idx;
    done_d       = 1'b0;
    we           = 1'b0;
    handshake    = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (start) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = SHIFT;
          end else begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_INIT;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt <= CNT_W'(1)) begin
          state_d      = SHIFT;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt - CNT_W'(1);
        end
      end
      SHIFT: begin
        we = 1'b1;
        if (wr_idx == LAST_IDX) begin
          state_d  = SEND;
          wr_idx_d = '0;
          rd_idx_d = '0;
        end else begin
          wr_idx_d = wr_idx + IDX_W'(1);
        end
      end
      SEND: begin
        if (handshake) begin
          if (rd_idx == LAST_IDX) begin
            state_d  = IDLE;
            rd_idx_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_idx_d = rd_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buffer slot feeding the next output byte
  always_comb begin
    rd_addr = rd_idx_d;
`ifdef DRAIN_ROW_MAJOR_EN
    rd_addr = LAST_IDX - rd_idx_d;
`endif
  end

  // Next output byte; bypass the buffer when the slot is written this same edge
  always_comb begin
    out_data_d = out_data;
    if (state_d == SEND) begin
      if (we && (wr_idx == rd_addr)) begin
        out_data_d = chain_in;
      end else begin
        out_data_d = rd_word;
      end
    end
  end

  // Counters and registered outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      busy       <= 1'b0;
      chain_en   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      settle_cnt <= settle_cnt_d;
      wr_idx     <= wr_idx_d;
      rd_idx     <= rd_idx_d;
      busy       <= (state_d != IDLE);
      chain_en   <= (state_d == SHIFT);
      out_valid  <= (state_d == SEND);
      out_last   <= (state_d == SEND) && (rd_idx_d == LAST_IDX);
      out_data   <= out_data_d;
      done       <= done_d;
    end
  end

  result_buffer #(
    .DATA_W    (DATA_W),
    .N_RESULTS (N_RESULTS),
    .IDX_W     (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .we      (we),
    .wr_idx  (wr_idx),
    .wdata   (chain_in),
    .rd_idx  (rd_addr),
    .rdata_c (rd_word)
  );

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: models the 2x2 accumulator chain, drives drains and
// scores the output stream against the expected byte order.
`timescale 1ns/1ps
module tb_result_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (settle 3)
  logic          start = 1'b0;
  logic          busy, chain_en, out_valid, out_last, done;
  logic [DW-1:0] chain_in, out_data;
  logic          out_ready = 1'b0;

  // Second instance (settle 0)
  logic          start1 = 1'b0;
  logic          busy1, chain_en1, out_valid1, out_last1, done1;
  logic [DW-1:0] chain_in1, out_data1;
  logic          out_ready1 = 1'b1;

  result_drain #(.DATA_W(DW), .N_RESULTS(NR), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .chain_en(chain_en),
    .chain_in(chain_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  result_drain #(.DATA_W(DW), .N_RESULTS(NR), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .chain_en(chain_en1),
    .chain_in(chain_in1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array chain model: index 0=C00, 1=C01, 2=C10, 3=C11 (tail)
  logic [DW-1:0] load_val [NR];
  logic [DW-1:0] arr  [NR];
  logic [DW-1:0] arr1 [NR];
  logic          load_req  = 1'b0;
  logic          load_req1 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) arr <= '{default: '0};
    else if (load_req) arr <= load_val;
    else if (chain_en) begin
      arr[3] <= arr[2]; arr[2] <= arr[1]; arr[1] <= arr[0]; arr[0] <= '0;
    end
  end
  assign chain_in = arr[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) arr1 <= '{default: '0};
    else if (load_req1) arr1 <= load_val;
    else if (chain_en1) begin
      arr1[3] <= arr1[2]; arr1[2] <= arr1[1]; arr1[1] <= arr1[0]; arr1[0] <= '0;
    end
  end
  assign chain_in1 = arr1[3];

  // Reference: k-th byte of a drain of the array loaded with load_val
  function automatic logic [DW:0] ref_entry(input int k);
    logic [DW-1:0] b;
`ifdef DRAIN_ROW_MAJOR_EN
    b = load_val[IW'(k)];
`else
    b = load_val[IW'(NR - 1 - k)];
`endif
    return {k == NR - 1, b};
  endfunction

  logic [DW:0] exp_q[$];
  logic [DW:0] got1[$];

  task automatic push_expected();
    for (int k = 0; k < NR; k++) exp_q.push_back(ref_entry(k));
  endtask

  // Cycle counter and monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_cnt = 0, en_rise = 0, en_last = 0, ov_rise = 0;
  int done_cnt = 0, hs_cnt = 0, last_cnt = 0;
  int en1_rise = 0, ov1_rise = 0, done1_cnt = 0;
  logic prev_en = 1'b0, prev_ov = 1'b0, prev_en1 = 1'b0, prev_ov1 = 1'b0;
  logic stall = 1'b0, stall_last = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (chain_en) begin
      en_cnt++;
      en_last = cyc;
      if (!prev_en) en_rise = cyc;
    end
    if (out_valid && !prev_ov) ov_rise = cyc;
    if (stall) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(stall_data));
      chk("stall_last", 64'(out_last), 64'(stall_last));
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", 64'(busy), 64'd0);
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (out_last) last_cnt++;
      chk("busy_at_hs", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got 0x%0h with no byte expected", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("data", 64'(out_data), 64'(e[DW-1:0]));
        chk("last", 64'(out_last), 64'(e[DW]));
      end
    end
    stall      = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
    prev_en    = chain_en;
    prev_ov    = out_valid;
    // second instance
    if (chain_en1 && !prev_en1) en1_rise = cyc;
    if (out_valid1 && !prev_ov1) ov1_rise = cyc;
    if (out_valid1) got1.push_back({out_last1, out_data1});
    if (done1) done1_cnt++;
    prev_en1 = chain_en1;
    prev_ov1 = out_valid1;
  end

  // Consumer ready: 0 always-ready, 1 fixed pattern, 2 random
  int          rdy_mode = 0;
  int          pidx = 0;
  logic [7:0]  pat = 8'b1011_0100;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        if (out_valid) begin
          out_ready = pat[pidx[2:0]];
          if (pidx < 7) pidx++;
        end else begin
          out_ready = 1'b0;
        end
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_arr(input logic [DW-1:0] a0, a1, a2, a3, input bit second);
    load_val[0] = a0; load_val[1] = a1; load_val[2] = a2; load_val[3] = a3;
    if (second) load_req1 = 1'b1; else load_req = 1'b1;
    tick();
    load_req  = 1'b0;
    load_req1 = 1'b0;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    sc    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", 64'(done_cnt >= target), 64'd1);
  endtask

  int sc, tmp, e0, d0, h0, l0, n;

  initial begin
    for (int i = 0; i < NR; i++) load_val[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_chain_en", 64'(chain_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic drain
    rdy_mode = 0;
    load_arr(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    e0 = en_cnt; d0 = done_cnt; h0 = hs_cnt; l0 = last_cnt;
    pulse_start(sc);
    push_expected();
    wait_done(d0 + 1, 40);
    tick(); tick();
    chk("basic_en_count", 64'(en_cnt - e0), 64'd4);
    chk("basic_en_first", 64'(en_rise - sc), 64'd4);
    chk("basic_en_lastcyc", 64'(en_last - sc), 64'd7);
    chk("basic_valid_first", 64'(ov_rise - sc), 64'd8);
    chk("basic_done_count", 64'(done_cnt - d0), 64'd1);
    chk("basic_hs_count", 64'(hs_cnt - h0), 64'd4);
    chk("basic_last_count", 64'(last_cnt - l0), 64'd1);
    chk("basic_array_zero", 64'({arr[3], arr[2], arr[1], arr[0]}), 64'd0);

    // Backpressure
    rdy_mode = 1; pidx = 0;
    load_arr(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start(sc);
    push_expected();
    wait_done(d0 + 1, 60);
    tick();
    chk("bp_hs_count", 64'(hs_cnt - h0), 64'd4);
    chk("bp_done_count", 64'(done_cnt - d0), 64'd1);
    chk("bp_busy_after", 64'(busy), 64'd0);

    // Start while busy: once in SETTLE, once in SEND
    rdy_mode = 0;
    load_arr(8'h5a, 8'h6b, 8'h7c, 8'h8d, 1'b0);
    e0 = en_cnt; d0 = done_cnt;
    pulse_start(sc);
    push_expected();
    tick();
    pulse_start(tmp);
    while (cyc < sc + 9) tick();
    pulse_start(tmp);
    wait_done(d0 + 1, 40);
    repeat (12) tick();
    chk("busy_start_en_count", 64'(en_cnt - e0), 64'd4);
    chk("busy_start_done_count", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_idle", 64'(busy), 64'd0);

    // Zero settle interval on the second instance
    load_arr(8'hc1, 8'hc2, 8'hc3, 8'hc4, 1'b1);
    got1.delete();
    tmp = done1_cnt;
    start1 = 1'b1; sc = cyc; tick(); start1 = 1'b0;
    n = 0;
    while (done1_cnt == tmp && n < 40) begin tick(); n++; end
    chk("s0_done", 64'(done1_cnt - tmp), 64'd1);
    chk("s0_en_first", 64'(en1_rise - sc), 64'd1);
    chk("s0_valid_first", 64'(ov1_rise - sc), 64'd5);
    chk("s0_byte_count", 64'(got1.size()), 64'd4);
    for (int k = 0; k < NR; k++) begin
      if (k < got1.size()) chk("s0_byte", 64'(got1[k]), 64'(ref_entry(k)));
    end

    // Reset in the middle of SHIFT
    load_arr(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    e0 = en_cnt;
    pulse_start(sc);
    push_expected();
    while (cyc < sc + 6) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_chain_en", 64'(chain_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_en_before", 64'(en_cnt - e0), 64'd2);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    load_arr(8'ha0, 8'ha1, 8'ha2, 8'ha3, 1'b0);
    e0 = en_cnt; d0 = done_cnt;
    pulse_start(sc);
    push_expected();
    wait_done(d0 + 1, 40);
    tick();
    chk("postrst_en_count", 64'(en_cnt - e0), 64'd4);
    chk("postrst_array_zero", 64'({arr[3], arr[2], arr[1], arr[0]}), 64'd0);

    // Back-to-back: second start in the done cycle
    load_arr(8'h51, 8'h52, 8'h53, 8'h54, 1'b0);
    e0 = en_cnt; d0 = done_cnt; h0 = hs_cnt; l0 = last_cnt;
    pulse_start(sc);
    push_expected();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    chk("b2b_first_done_seen", 64'(done), 64'd1);
    load_val[0] = 8'h61; load_val[1] = 8'h62; load_val[2] = 8'h63; load_val[3] = 8'h64;
    load_req = 1'b1;
    start    = 1'b1;
    push_expected();
    tick();
    start    = 1'b0;
    load_req = 1'b0;
    wait_done(d0 + 2, 60);
    tick();
    chk("b2b_hs_count", 64'(hs_cnt - h0), 64'd8);
    chk("b2b_last_count", 64'(last_cnt - l0), 64'd2);
    chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);
    chk("b2b_en_count", 64'(en_cnt - e0), 64'd8);

    // Random data with random consumer stalls
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      load_arr(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      e0 = en_cnt; d0 = done_cnt;
      pulse_start(sc);
      push_expected();
      wait_done(d0 + 1, 200);
      repeat ($urandom_range(0, 3)) tick();
      chk("rand_en_count", 64'(en_cnt - e0), 64'd4);
      chk("rand_array_zero", 64'({arr[3], arr[2], arr[1], arr[0]}), 64'd0);
    end

    rdy_mode = 0;
    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);
    chk("final_idle_s0", 64'(busy1), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
